// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - shared memory-game constants
// Purpose: FSM state encodings, the 59.99 time limit digits and the
//          default tick divider shared by the game timer files.
// Ports:   none (package).
package game_timer_pkg;

  // 650000 cycles of the 65 MHz pixel clock make one 1/100 s tick.
  localparam int DEFAULT_CLK_DIV = 650000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WON  = 2'd2,
    ST_LOST = 2'd3
  } state_t;

  // Time limit 59.99 s, one constant per BCD digit.
  localparam logic [2:0] LIM_SEC_D = 3'd5;
  localparam logic [3:0] LIM_SEC_U = 4'd9;
  localparam logic [3:0] LIM_HUN_D = 4'd9;
  localparam logic [3:0] LIM_HUN_U = 4'd9;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - 1/100 s tick prescaler
// Purpose: counts 0..CLK_DIV-1 while enabled and flags the wrap to 0.
// Ports:   clk  in  system clock
//          rst  in  synchronous active-high reset
//          en   in  count enable (game running)
//          clr  in  synchronous clear (game restart)
//          tick out one-cycle pulse on the cycle the count wraps
module tick_gen
  import game_timer_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  // Tick is combinational so the consumer registers its effect on the
  // same edge the counter wraps.
  assign w_wrap = en && (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_wrap) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_timer.sv
// rtl/game_timer.sv - memory-game BCD timer, pair counter and win/lose FSM
// Purpose: runs a 00.00..59.99 s BCD clock while a game is in progress,
//          counts matched pairs and decides between WON and LOST.
// Ports:   clk                  in  system clock
//          rst                  in  synchronous active-high reset
//          start                in  pulse: clear and (re)start a game
//          pair_found           in  pulse: one pair matched
//          seconds_dozens_unity out BCD seconds {dozens[2:0], unity[3:0]}
//          hundredths_of_second out BCD hundredths {dozens, unity}
//          discovered_pairs_ctr out pairs {3'b0, unity[2:0]}
//          game_over_en         out high while LOST
//          game_won             out high while WON
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int NUM_PAIRS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pair_found,
  output logic [6:0] seconds_dozens_unity,
  output logic [7:0] hundredths_of_second,
  output logic [5:0] discovered_pairs_ctr,
  output logic       game_over_en,
  output logic       game_won
);

  localparam logic [2:0] PAIRS_ALL  = 3'(NUM_PAIRS);
  localparam logic [2:0] PAIRS_LAST = 3'(NUM_PAIRS - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_sec_d;
  logic [3:0] r_sec_u;
  logic [3:0] r_hun_d;
  logic [3:0] r_hun_u;
  logic [2:0] r_pairs;
  logic       r_game_over;
  logic       r_game_won;

  logic w_run;
  logic w_tick;
  logic w_at_limit;
  logic w_final_pair;
  logic w_time_step;
  logic w_game_over_next;
  logic w_game_won_next;

  assign w_run = (r_state == ST_RUN);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (w_run),
    .clr  (start),
    .tick (w_tick)
  );

  assign w_at_limit   = (r_sec_d == LIM_SEC_D) && (r_sec_u == LIM_SEC_U) &&
                        (r_hun_d == LIM_HUN_D) && (r_hun_u == LIM_HUN_U);
  assign w_final_pair = w_run && pair_found && (r_pairs == PAIRS_LAST);
  // The clock never advances past 59.99; the limit tick only changes state.
  assign w_time_step  = w_run && w_tick && !w_at_limit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: start wins over everything but rst, and the final
  // pair wins over the limit tick.
  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (w_final_pair)              w_state_next = ST_WON;
      else if (w_tick && w_at_limit) w_state_next = ST_LOST;
    end
  end

  // Output logic, registered so flags line up with the counters.
  always_comb begin
    w_game_over_next = (w_state_next == ST_LOST);
    w_game_won_next  = (w_state_next == ST_WON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_game_over <= 1'b0;
      r_game_won  <= 1'b0;
    end else begin
      r_game_over <= w_game_over_next;
      r_game_won  <= w_game_won_next;
    end
  end

  // Pair counter and BCD time cascade; both only move while running.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_pairs <= '0;
      r_sec_d <= '0;
      r_sec_u <= '0;
      r_hun_d <= '0;
      r_hun_u <= '0;
    end else begin
      if (w_run && pair_found && (r_pairs < PAIRS_ALL)) begin
        r_pairs <= r_pairs + 3'd1;
      end
      if (w_time_step) begin
        if (r_hun_u != 4'd9) begin
          r_hun_u <= r_hun_u + 4'd1;
        end else begin
          r_hun_u <= 4'd0;
          if (r_hun_d != 4'd9) begin
            r_hun_d <= r_hun_d + 4'd1;
          end else begin
            r_hun_d <= 4'd0;
            if (r_sec_u != 4'd9) begin
              r_sec_u <= r_sec_u + 4'd1;
            end else begin
              // Seconds dozens below 5 here: 59.99 never steps.
              r_sec_u <= 4'd0;
              r_sec_d <= r_sec_d + 3'd1;
            end
          end
        end
      end
    end
  end

  assign seconds_dozens_unity = {r_sec_d, r_sec_u};
  assign hundredths_of_second = {r_hun_d, r_hun_u};
  assign discovered_pairs_ctr = {3'b000, r_pairs};
  assign game_over_en         = r_game_over;
  assign game_won             = r_game_won;

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - scoreboard bench for game_timer
module tb_game_timer;

  localparam int DIV = 4;
  localparam int NP  = 6;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_WON  = 2;
  localparam int P_LOST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pair_found = 1'b0;
  logic [6:0] seconds_dozens_unity;
  logic [7:0] hundredths_of_second;
  logic [5:0] discovered_pairs_ctr;
  logic       game_over_en;
  logic       game_won;

  game_timer #(
    .CLK_DIV   (DIV),
    .NUM_PAIRS (NP)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .pair_found           (pair_found),
    .seconds_dozens_unity (seconds_dozens_unity),
    .hundredths_of_second (hundredths_of_second),
    .discovered_pairs_ctr (discovered_pairs_ctr),
    .game_over_en         (game_over_en),
    .game_won             (game_won)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sec;
    int hun;
    int pairs;
    int over;
    int won;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;

  // Reference model: elapsed time in hundredths, pairs, game phase and
  // the number of clock cycles spent running since the last start.
  int m_phase = P_IDLE;
  int m_t     = 0;
  int m_pairs = 0;
  int m_rc    = 0;

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic bit tick_next();
    return (m_phase == P_RUN) && (((m_rc + 1) % DIV) == 0);
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit p);
    bit tk;
    if (r) begin
      m_phase = P_IDLE; m_t = 0; m_pairs = 0; m_rc = 0;
    end else if (s) begin
      m_phase = P_RUN;  m_t = 0; m_pairs = 0; m_rc = 0;
    end else if (m_phase == P_RUN) begin
      tk   = tick_next();
      m_rc = m_rc + 1;
      if (p) begin
        m_pairs = m_pairs + 1;
        if (m_pairs == NP) m_phase = P_WON;
      end
      if (tk) begin
        if (m_t == 5999) begin
          if (m_phase != P_WON) m_phase = P_LOST;
        end else begin
          m_t = m_t + 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_max(input string nm, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: digit %0d exceeds limit %0d at %0t", nm, act, lim, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit p);
    exp_t e;
    rst = r; start = s; pair_found = p;
    model_edge(r, s, p);
    e.sec   = to_bcd(m_t / 100);
    e.hun   = to_bcd(m_t % 100);
    e.pairs = m_pairs;
    e.over  = (m_phase == P_LOST) ? 1 : 0;
    e.won   = (m_phase == P_WON) ? 1 : 0;
    @(posedge clk);
    q.push_back(e);
    armed = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic bound_fail(input string nm, input int budget);
    checks++;
    errors++;
    $display("FAIL %s: bound of %0d cycles expired", nm, budget);
  endtask

  task automatic run_until_t(input int target, input int budget);
    int n = 0;
    while (m_t != target && n < budget) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_t != target) bound_fail("run_until_t", budget);
  endtask

  // Monitor: digit-range checker every cycle, scoreboard pop per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      chk_max("sec_dozens", int'(seconds_dozens_unity[6:4]), 5);
      chk_max("sec_unity",  int'(seconds_dozens_unity[3:0]), 9);
      chk_max("hun_dozens", int'(hundredths_of_second[7:4]), 9);
      chk_max("hun_unity",  int'(hundredths_of_second[3:0]), 9);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("seconds",   int'(seconds_dozens_unity), e.sec);
        chk("hundredth", int'(hundredths_of_second), e.hun);
        chk("pairs",     int'(discovered_pairs_ctr), e.pairs);
        chk("game_over", int'(game_over_en),         e.over);
        chk("game_won",  int'(game_won),             e.won);
      end
    end
  end

  initial begin
    int n;
    // Reset state
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);

    // Pairs in IDLE are ignored
    cyc(1'b0, 1'b0, 1'b1);
    idle(3);
    cyc(1'b0, 1'b0, 1'b1);

    // 400 cycles after start -> 01.00
    cyc(1'b0, 1'b1, 1'b0);
    idle(400);

    // Run to the time limit, then prove the LOST outputs are frozen
    n = 0;
    while (m_phase != P_LOST && n < 30000) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_phase != P_LOST) bound_fail("reach_lost", 30000);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'((i % 5) == 0));

    // Six pairs at ticks 10..15 -> WON, seventh pulse ignored
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 10; k <= 15; k++) begin
      run_until_t(k, 200);
      cyc(1'b0, 1'b0, 1'b1);
    end
    idle(20);
    cyc(1'b0, 1'b0, 1'b1);
    idle(10);

    // Final pair together with the 59.99 tick -> WON wins
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      idle(3);
    end
    n = 0;
    while (!(m_t == 5999 && tick_next()) && n < 30000) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!(m_t == 5999 && tick_next())) bound_fail("reach_limit_tick", 30000);
    cyc(1'b0, 1'b0, 1'b1);
    idle(20);

    // Restart mid-game at 12.34 with 3 pairs, then reset mid-run
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      idle(2);
    end
    run_until_t(1234, 6000);
    cyc(1'b0, 1'b1, 1'b1);
    idle(30);
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 999) == 0),
          1'($urandom_range(0, 299) == 0),
          1'($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) bound_fail("scoreboard_drain", 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter CLK_DIV, default 650000, number of clk cycles per 1/100 s tick (65 MHz pixel clock).
REQ-002 Parameter NUM_PAIRS, default 6, pairs needed to win; legal range 1..7.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle pulse; clear and (re)start a game.
REQ-006 pair_found  in  1  one-cycle pulse; one pair matched.
REQ-007 seconds_dozens_unity  out  7  BCD seconds {dozens[2:0], unity[3:0]}, registered.
REQ-008 hundredths_of_second  out  8  BCD hundredths {dozens[3:0], unity[3:0]}, registered.
REQ-009 discovered_pairs_ctr  out  6  pairs {dozens[2:0], unity[2:0]}, registered; dozens always 0.
REQ-010 game_over_en  out  1  high while in LOST, registered.
REQ-011 game_won  out  1  high while in WON, registered.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, WON, LOST.
REQ-013 start SHALL, from any state, clear time, pairs and tick prescaler, then enter RUN on the next edge.
REQ-014 The prescaler SHALL count 0..CLK_DIV-1 only in RUN and emit a one-cycle tick when wrapping to 0.
REQ-015 Each tick SHALL add 0.01 s in BCD: hundredths unity 9->0 carries to hundredths dozens; 99->00 carries to seconds unity; 9->0 carries to seconds dozens; dozens range 0..5.
REQ-016 A tick at 59.99 SHALL hold time at 59.99 and move RUN->LOST.
REQ-017 pair_found in RUN SHALL increment the pair count by 1; pulses outside RUN SHALL be ignored.
REQ-018 The count reaching NUM_PAIRS SHALL move RUN->WON on that edge; the count SHALL never exceed NUM_PAIRS.
REQ-019 If the final pair_found and the 59.99 tick occur in the same cycle, WON SHALL take priority and time SHALL hold 59.99.
REQ-020 In WON and LOST all counters SHALL freeze; outputs hold final values until start or rst.
REQ-021 In IDLE the outputs SHALL read 00.00 and 0 pairs.
REQ-022 A start coinciding with pair_found or tick SHALL take priority; counts restart from zero.
REQ-023 Outputs SHALL update one cycle after the causing event.
REQ-024 The BCD digit fields SHALL never hold values above 9, or above 5 for seconds dozens.

Reset
REQ-025 rst SHALL force state IDLE, prescaler 0, seconds_dozens_unity 7'h00, hundredths_of_second 8'h00, discovered_pairs_ctr 6'h00, game_over_en 0, game_won 0.
REQ-026 rst SHALL override start and every other input in the same cycle, including mid-RUN.

Structure
REQ-027 The FSM state encodings, the 59.99 limit digits and the default CLK_DIV SHALL sit in the shared memory-game constants package.
REQ-028 The prescaler SHALL be a sub-module tick_gen (params CLK_DIV; ports clk, rst, en, clr, tick).
REQ-029 The BCD cascade and FSM SHALL be in game_timer; no other sub-modules.

Verification (bench uses CLK_DIV=4)
REQ-030 rst, then start, run 400 cycles -> time reads 01.00 (seconds 7'h01, hundredths 8'h00), state RUN.
REQ-031 Run to 6000 ticks -> game_over_en=1 with time frozen at 59.99 (7'h59, 8'h99); further ticks and pair_found do not change the outputs.
REQ-032 Six pair_found pulses at ticks 10..15 -> game_won=1, discovered_pairs_ctr=6'h06, time frozen; a 7th pulse is ignored.
REQ-033 Fifth pair already found and final pair_found in the same cycle as the tick at 59.99 -> game_won=1, game_over_en=0, time 59.99.
REQ-034 start during RUN at 12.34 with 3 pairs -> next cycle time 00.00, pairs 0, RUN; rst mid-RUN -> IDLE with all outputs 0.
REQ-035 Checker: every BCD nibble is at most 9 and seconds dozens at most 5 in every cycle; pair_found pulses in IDLE leave the count at 0.
